// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM encoding, key_code field positions and row constants shared by keypad emulator and driver.
package keypad_pkg;
    typedef enum logic [2:0] {S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP} state_t;
    localparam int ROW_MSB = 3;
    localparam int COL_LSB = 0;
    localparam logic [3:0] ROW_IDLE = 4'b1111;
    function automatic logic [1:0] key_row(input logic [3:0] k);
        return k[ROW_MSB -: 2];
    endfunction
    function automatic logic [1:0] key_col(input logic [3:0] k);
        return k[COL_LSB +: 2];
    endfunction
endpackage

// File: rtl/key_fifo.sv
// key_fifo: power-of-two depth synchronous FIFO with count/full/empty and async active-low reset.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];
    always_comb begin
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad responder that replays queued key codes as timed presses with optional bounce.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int PRESS_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES    = 25_000_000,
    parameter int BOUNCE_CYCLES = 50_000,
    parameter int BOUNCE_HALF   = 5_000,
    parameter int DEPTH         = 4,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] fila,
    output logic       busy,
    output logic       key_done
);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(BOUNCE_HALF - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [3:0]       cur_key_q, cur_key_d, head;
    logic             contact_q, contact_d, key_done_q, key_done_d, busy_q, busy_d;
    logic             push, pop, full, empty, wrap;
    key_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(key_code),
        .dout(head), .full(full), .empty(empty)
    );
    assign key_ready = !full;
    assign push      = key_valid && key_ready;
    assign busy      = busy_q;
    assign key_done  = key_done_q;
    assign wrap      = hcnt_q == H_LAST;
    // Zero-latency switch: only the pressed key's column can pull its row low.
    assign fila = (contact_q && !col[key_col(cur_key_q)]) ? ~(4'b0001 << key_row(cur_key_q)) : ROW_IDLE;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        hcnt_d     = wrap ? '0 : hcnt_q + 1'b1;
        contact_d  = contact_q;
        cur_key_d  = cur_key_q;
        key_done_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                hcnt_d    = '0;
                contact_d = 1'b0;
                if (!empty) begin
                    pop       = 1'b1;
                    cur_key_d = head;
                    contact_d = 1'b1;
                    state_d   = (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE_IN;
                end
            end
            S_BOUNCE_IN: begin
                contact_d = contact_q ^ wrap;
                if (cnt_q == B_LAST) begin
                    state_d   = S_HOLD;
                    cnt_d     = '0;
                    contact_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == P_LAST) begin
                    state_d   = (BOUNCE_CYCLES == 0) ? S_GAP : S_BOUNCE_OUT;
                    cnt_d     = '0;
                    hcnt_d    = '0;
                    contact_d = 1'b0;
                end
            end
            S_BOUNCE_OUT: begin
                contact_d = contact_q ^ wrap;
                if (cnt_q == B_LAST) begin
                    state_d   = S_GAP;
                    cnt_d     = '0;
                    contact_d = 1'b0;
                end
            end
            S_GAP: begin
                if (cnt_q == G_LAST) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    key_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_q != S_IDLE) || !empty || push;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            contact_q  <= 1'b0;
            cur_key_q  <= '0;
            key_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            contact_q  <= contact_d;
            cur_key_q  <= cur_key_d;
            key_done_q <= key_done_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed self-checking bench for keypad_emulator (no-bounce and bounce instances).
module tb_keypad_emulator;
    logic clk = 1'b0;
    logic reset, key_valid, key_ready, busy, key_done;
    logic [3:0] key_code, col, fila;
    logic b_reset, b_valid, b_ready, b_busy, b_done;
    logic [3:0] b_code, b_col, b_fila;
    int checks = 0;
    int errors = 0;
    int npress, ndone, w;
    int rows [16];
    int gaps [16];
    logic [3:0] cyc [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] burst [5] = '{4'h5, 4'hA, 4'hF, 4'h3, 4'hC};
    int t3_rows [4] = '{1, 2, 3, 0};
    localparam logic [0:19] BEXP = 20'b0101_0000_0000_1010_1111;

    always #5 clk = ~clk;

    keypad_emulator #(.PRESS_CYCLES(8), .GAP_CYCLES(4), .BOUNCE_CYCLES(0), .BOUNCE_HALF(1),
                      .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .col(col), .fila(fila), .busy(busy), .key_done(key_done)
    );

    keypad_emulator #(.PRESS_CYCLES(8), .GAP_CYCLES(4), .BOUNCE_CYCLES(4), .BOUNCE_HALF(1),
                      .DEPTH(4), .CNT_W(8)) dut_b (
        .clk(clk), .reset(b_reset), .key_valid(b_valid), .key_code(b_code), .key_ready(b_ready),
        .col(b_col), .fila(b_fila), .busy(b_busy), .key_done(b_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int fila_row(input logic [3:0] f);
        for (int r = 0; r < 4; r++) if (!f[r]) return r;
        return -1;
    endfunction

    // Records new presses (row, preceding release length) and key_done pulses on the main instance.
    task automatic watch(input int n, input logic [3:0] p0);
        logic [3:0] prev;
        int gap;
        prev = p0;
        gap = 0;
        npress = 0;
        ndone = 0;
        for (int c = 0; c < n; c++) begin
            tick;
            if (key_done) ndone++;
            if (fila != 4'hF && prev == 4'hF) begin
                if (npress < 16) begin
                    rows[npress] = fila_row(fila);
                    gaps[npress] = gap;
                end
                npress++;
            end
            if (fila == 4'hF) gap = (prev == 4'hF) ? gap + 1 : 1;
            prev = fila;
        end
    endtask

    initial begin
        reset = 1'b0; b_reset = 1'b0; key_valid = 1'b0; key_code = '0; col = 4'hF;
        b_valid = 1'b0; b_code = '0; b_col = 4'h0;
        for (int i = 0; i < 4; i++) begin
            col = cyc[i];
            tick;
            chk("rst_fila", fila, 4'hF);
            chk("rst_ready", key_ready, 1);
            chk("rst_busy", busy, 0);
        end
        chk("rst_done", key_done, 0);
        reset = 1'b1; b_reset = 1'b1;
        tick;

        col = 4'b1011; key_code = 4'h6; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        chk("t2_busy", busy, 1);
        chk("t2_prepop", fila, 4'hF);
        tick;
        for (int i = 0; i < 8; i++) begin
            chk("t2_hold", fila, 4'b1101);
            if (i == 3) begin
                col = 4'b1110;
                #1 chk("t2_othercol", fila, 4'hF);
                col = 4'b1011;
                #1;
            end
            tick;
        end
        chk("t2_release", fila, 4'hF);
        for (int i = 0; i < 4; i++) begin
            chk("t2_nodone", key_done, 0);
            tick;
        end
        chk("t2_done", key_done, 1);
        chk("t2_busy_done", busy, 1);
        tick;
        chk("t2_done_once", key_done, 0);
        chk("t2_idle_busy", busy, 0);

        col = 4'h0; key_code = 4'h0; key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            key_code = burst[i];
            key_valid = 1'b1;
            chk("t3_ready", key_ready, (i < 4) ? 1 : 0);
            tick;
        end
        key_valid = 1'b0;
        chk("t3_full", key_ready, 0);
        watch(150, fila);
        chk("t3_npress", npress, 4);
        chk("t3_ndone", ndone, 5);
        for (int i = 0; i < 4; i++) begin
            chk("t3_row", rows[i], t3_rows[i]);
            chk("t3_gap", gaps[i], 5);
        end
        chk("t3_busy_end", busy, 0);

        b_code = 4'h0; b_valid = 1'b1;
        tick;
        b_valid = 1'b0;
        tick;
        for (int i = 0; i < 20; i++) begin
            chk("t4_bounce", b_fila[0], BEXP[i]);
            tick;
        end

        key_code = 4'h0; key_valid = 1'b1;
        tick;
        key_code = 4'h5;
        tick;
        key_code = 4'hA;
        tick;
        key_valid = 1'b0;
        tick;
        chk("t5_hold", fila, 4'b1110);
        chk("t5_count", dut.u_fifo.count_q, 2);
        reset = 1'b0;
        #1;
        chk("t5_fila", fila, 4'hF);
        chk("t5_ready", key_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_flush", dut.u_fifo.count_q, 0);
        tick;
        tick;
        reset = 1'b1;
        watch(40, 4'hF);
        chk("t5_npress", npress, 0);
        chk("t5_ndone", ndone, 0);

        key_code = 4'h1; key_valid = 1'b1;
        tick;
        key_code = 4'h6;
        tick;
        key_code = 4'h9;
        tick;
        key_valid = 1'b0;
        chk("t6_count", dut.u_fifo.count_q, 2);
        w = 0;
        while (!key_done && w < 50) begin
            tick;
            w++;
        end
        chk("t6_wait_done", key_done, 1);
        key_code = 4'hE; key_valid = 1'b1;
        chk("t6_pre", dut.u_fifo.count_q, 2);
        tick;
        key_valid = 1'b0;
        chk("t6_pushpop", dut.u_fifo.count_q, 2);
        watch(60, 4'hF);
        chk("t6_npress", npress, 3);
        chk("t6_ndone", ndone, 3);
        for (int i = 0; i < 3; i++) chk("t6_row", rows[i], i + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
